// File: rtl/zap_fetch_pkg.sv
// rtl/zap_fetch_pkg.sv - shared fetch types: predictor states, abort payload, queue entry layout.
package zap_fetch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_state_t;

  localparam logic [31:0] ABORT_PAYLOAD = 32'd0;

  typedef struct packed {
    logic [31:0] instruction;
    logic        abort;
    logic [31:0] pc;
    logic [31:0] pc_plus_8;
    bp_state_t   taken;
  } fetch_entry_t;

  localparam fetch_entry_t ENTRY_RESET = '{
    instruction: 32'd0,
    abort:       1'b0,
    pc:          32'd0,
    pc_plus_8:   32'd8,
    taken:       SNT
  };

  // A clear means the branch went the other way; a confirm reinforces toward not-taken or taken.
  function automatic bp_state_t bp_next(input bp_state_t taken, input logic clear);
    bp_state_t nxt;
    nxt = taken;
    if (clear) begin
      case (taken)
        SNT:     nxt = WNT;
        WNT:     nxt = WT;
        WT:      nxt = WNT;
        default: nxt = WT;
      endcase
    end else begin
      case (taken)
        SNT:     nxt = SNT;
        WNT:     nxt = SNT;
        WT:      nxt = ST;
        default: nxt = ST;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/zap_bp_table.sv
// rtl/zap_bp_table.sv - branch predictor counter table, combinational read, synchronous write.
module zap_bp_table
  import zap_fetch_pkg::*;
#(
  parameter int ENTRIES = 1024,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             i_clk,
  input  logic [IDX_W-1:0] i_rd_idx,
  output bp_state_t        o_rd_state,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  bp_state_t        i_wr_state
);

  bp_state_t r_mem [ENTRIES];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_idx] <= i_wr_state;
  end

  assign o_rd_state = r_mem[i_rd_idx];

endmodule

// File: rtl/zap_prefetch_queue.sv
// rtl/zap_prefetch_queue.sv - fetch-to-decode prefetch queue with optional branch predictor.
// Predictor is built only when ZAP_FETCH_BP_EN is defined; otherwise every word reads SNT.
module zap_prefetch_queue
  import zap_fetch_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int BP_ENTRIES = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_clear_from_writeback,
  input  logic                     i_data_stall,
  input  logic                     i_clear_from_alu,
  input  logic                     i_stall_from_shifter,
  input  logic                     i_stall_from_issue,
  input  logic                     i_stall_from_decode,
  input  logic                     i_clear_from_decode,
  input  logic [31:0]              i_pc_ff,
  input  logic                     i_cpsr_t,
  input  logic [31:0]              i_instruction,
  input  logic                     i_valid,
  input  logic                     i_instr_abort,
  output logic                     o_ready,
  output logic [31:0]              o_instruction,
  output logic                     o_valid,
  output logic                     o_instr_abort,
  output logic [31:0]              o_pc_ff,
  output logic [31:0]              o_pc_plus_8_ff,
  output logic [1:0]               o_taken_ff,
  output logic [$clog2(DEPTH):0]   o_level,
  input  logic                     i_confirm_from_alu,
  input  logic [31:0]              i_pc_from_alu,
  input  logic [1:0]               i_taken
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int BP_IDX_W = $clog2(BP_ENTRIES);

  fetch_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_sleep;

  logic                  w_stall;
  logic                  w_flush;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  bp_state_t             w_taken;
  logic [BP_IDX_W-1:0]   w_bp_rd_idx;
  fetch_entry_t          w_new;
  fetch_entry_t          w_head;

  assign w_stall = i_data_stall | i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode;
  assign w_flush = i_clear_from_writeback | (!i_data_stall & i_clear_from_alu)
                 | (!w_stall & i_clear_from_decode);
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign o_ready = i_reset_n & !w_full & !r_sleep & !w_flush;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & !w_stall & !w_flush;

  assign w_bp_rd_idx = i_pc_ff[BP_IDX_W:1];

`ifdef ZAP_FETCH_BP_EN
  logic                w_bp_wr_en;
  logic [BP_IDX_W-1:0] w_bp_wr_idx;
  bp_state_t           w_bp_wr_state;
  logic                w_unused;

  assign w_bp_wr_en    = !i_data_stall & (i_clear_from_alu | i_confirm_from_alu);
  assign w_bp_wr_idx   = i_pc_from_alu[BP_IDX_W:1];
  assign w_bp_wr_state = bp_next(bp_state_t'(i_taken), i_clear_from_alu);
  assign w_unused      = ^{i_pc_from_alu[31:BP_IDX_W+1], i_pc_from_alu[0]};

  zap_bp_table #(.ENTRIES(BP_ENTRIES)) u_bp_table (
    .i_clk      (i_clk),
    .i_rd_idx   (w_bp_rd_idx),
    .o_rd_state (w_taken),
    .i_wr_en    (w_bp_wr_en),
    .i_wr_idx   (w_bp_wr_idx),
    .i_wr_state (w_bp_wr_state)
  );
`else
  logic w_unused;

  assign w_taken  = SNT;
  assign w_unused = ^{i_confirm_from_alu, i_pc_from_alu, i_taken, w_bp_rd_idx};
`endif

  assign w_new.instruction = i_instr_abort ? ABORT_PAYLOAD : i_instruction;
  assign w_new.abort       = i_instr_abort;
  assign w_new.pc          = i_pc_ff;
  assign w_new.pc_plus_8   = i_pc_ff + (i_cpsr_t ? 32'd4 : 32'd8);
  assign w_new.taken       = w_taken;

  // Head is read straight from storage, so a pushed word appears only after its write edge.
  assign w_head         = r_mem[r_rd_ptr];
  assign o_valid        = (r_level != '0);
  assign o_instruction  = w_head.instruction;
  assign o_instr_abort  = w_head.abort;
  assign o_pc_ff        = w_head.pc;
  assign o_pc_plus_8_ff = w_head.pc_plus_8;
  assign o_taken_ff     = w_head.taken;
  assign o_level        = r_level;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_sleep  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= ENTRY_RESET;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
      r_sleep  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_new;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        if (i_instr_abort) r_sleep <= 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_zap_prefetch_queue.sv
// tb/tb_zap_prefetch_queue.sv - directed self-checking bench for zap_prefetch_queue.
module tb_zap_prefetch_queue;
  import zap_fetch_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter;
  logic        i_stall_from_issue, i_stall_from_decode, i_clear_from_decode;
  logic [31:0] i_pc_ff, i_instruction, i_pc_from_alu;
  logic        i_cpsr_t, i_valid, i_instr_abort, i_confirm_from_alu;
  logic [1:0]  i_taken;
  logic        o_ready, o_valid, o_instr_abort;
  logic [31:0] o_instruction, o_pc_ff, o_pc_plus_8_ff;
  logic [1:0]  o_taken_ff;
  logic [2:0]  o_level;

  int n_cmp = 0;
  int n_err = 0;

  zap_prefetch_queue #(.DEPTH(4), .BP_ENTRIES(1024)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
    .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
    .i_stall_from_issue(i_stall_from_issue), .i_stall_from_decode(i_stall_from_decode),
    .i_clear_from_decode(i_clear_from_decode), .i_pc_ff(i_pc_ff), .i_cpsr_t(i_cpsr_t),
    .i_instruction(i_instruction), .i_valid(i_valid), .i_instr_abort(i_instr_abort),
    .o_ready(o_ready), .o_instruction(o_instruction), .o_valid(o_valid),
    .o_instr_abort(o_instr_abort), .o_pc_ff(o_pc_ff), .o_pc_plus_8_ff(o_pc_plus_8_ff),
    .o_taken_ff(o_taken_ff), .o_level(o_level), .i_confirm_from_alu(i_confirm_from_alu),
    .i_pc_from_alu(i_pc_from_alu), .i_taken(i_taken)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wb_flush();
    i_clear_from_writeback = 1'b1;
    i_valid = 1'b0;
    tick();
    i_clear_from_writeback = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    i_reset_n = 1'b0;
    {i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter} = '0;
    {i_stall_from_issue, i_stall_from_decode, i_clear_from_decode} = '0;
    i_pc_ff = '0; i_instruction = '0; i_pc_from_alu = '0; i_cpsr_t = 1'b0;
    i_valid = 1'b0; i_instr_abort = 1'b0; i_confirm_from_alu = 1'b0; i_taken = 2'd0;
    tick();
    tick();
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_abort", 32'(o_instr_abort), 32'd0);
    check("rst_pc", o_pc_ff, 32'd0);
    check("rst_pc8", o_pc_plus_8_ff, 32'd8);
    check("rst_taken", 32'(o_taken_ff), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    i_reset_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(o_ready), 32'd1);

    // Fill to DEPTH under stall, reject a fifth word, then drain in order.
    i_stall_from_issue = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1;
      i_pc_ff = 32'h1000 + 32'(4 * k);
      i_instruction = 32'hA000_0000 + 32'(k);
      tick();
    end
    check("full_level", 32'(o_level), 32'd4);
    check("full_ready", 32'(o_ready), 32'd0);
    check("full_head", o_instruction, 32'hA000_0000);
    i_pc_ff = 32'h1010;
    i_instruction = 32'hA000_0004;
    tick();
    check("fifth_level", 32'(o_level), 32'd4);
    check("stall_hold", o_instruction, 32'hA000_0000);
    i_valid = 1'b0;
    i_stall_from_issue = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("drain_instr", o_instruction, 32'hA000_0000 + 32'(k));
      check("drain_pc", o_pc_ff, 32'h1000 + 32'(4 * k));
      check("drain_pc8", o_pc_plus_8_ff, 32'h1008 + 32'(4 * k));
      tick();
    end
    check("drained_level", 32'(o_level), 32'd0);
    check("drained_valid", 32'(o_valid), 32'd0);

    // ARM vs Thumb PC+8 and 32-bit wrap; no combinational bypass.
    i_valid = 1'b1; i_pc_ff = 32'h100; i_cpsr_t = 1'b0; i_instruction = 32'h11;
    #1;
    check("no_bypass", 32'(o_valid), 32'd0);
    tick();
    i_pc_ff = 32'h104; i_cpsr_t = 1'b1; i_instruction = 32'h22;
    #1;
    check("arm_pc", o_pc_ff, 32'h100);
    check("arm_pc8", o_pc_plus_8_ff, 32'h108);
    tick();
    i_valid = 1'b0; i_cpsr_t = 1'b0;
    #1;
    check("pushpop_level", 32'(o_level), 32'd1);
    check("thumb_pc", o_pc_ff, 32'h104);
    check("thumb_pc8", o_pc_plus_8_ff, 32'h108);
    tick();
    i_valid = 1'b1; i_pc_ff = 32'hFFFF_FFFC;
    tick();
    i_valid = 1'b0;
    #1;
    check("wrap_pc8", o_pc_plus_8_ff, 32'h4);
    tick();
    check("wrap_empty", 32'(o_level), 32'd0);

    // Abort word sleeps the queue until an ALU clear.
    i_stall_from_issue = 1'b1;
    i_valid = 1'b1; i_pc_ff = 32'h200; i_instruction = 32'hDEAD_BEEF; i_instr_abort = 1'b1;
    tick();
    i_instr_abort = 1'b0; i_pc_ff = 32'h204; i_instruction = 32'h33;
    #1;
    check("abort_instr", o_instruction, 32'h0);
    check("abort_flag", 32'(o_instr_abort), 32'd1);
    check("abort_pc", o_pc_ff, 32'h200);
    check("sleep_ready", 32'(o_ready), 32'd0);
    tick();
    check("sleep_level", 32'(o_level), 32'd1);
    i_valid = 1'b0;
    i_clear_from_alu = 1'b1; i_pc_from_alu = 32'h0; i_taken = 2'd0;
    #1;
    check("clear_ready", 32'(o_ready), 32'd0);
    tick();
    i_clear_from_alu = 1'b0;
    #1;
    check("clear_valid", 32'(o_valid), 32'd0);
    check("clear_level", 32'(o_level), 32'd0);
    check("wake_ready", 32'(o_ready), 32'd1);

    // ALU clear blocked by data stall; writeback clear is not.
    i_clear_from_alu = 1'b1; i_pc_from_alu = 32'h400; i_taken = 2'(SNT);
    tick();
    i_clear_from_alu = 1'b0;
    i_valid = 1'b1; i_pc_ff = 32'h300; i_instruction = 32'h44;
    tick();
    i_valid = 1'b0;
    i_data_stall = 1'b1; i_clear_from_alu = 1'b1; i_taken = 2'(ST);
    #1;
    check("dstall_ready", 32'(o_ready), 32'd1);
    tick();
    i_clear_from_alu = 1'b0;
    #1;
    check("dstall_level", 32'(o_level), 32'd1);
    check("dstall_head", o_instruction, 32'h44);
    i_clear_from_writeback = 1'b1;
    #1;
    check("wb_ready", 32'(o_ready), 32'd0);
    tick();
    i_clear_from_writeback = 1'b0; i_data_stall = 1'b0;
    #1;
    check("wb_valid", 32'(o_valid), 32'd0);
    check("wb_level", 32'(o_level), 32'd0);
    i_valid = 1'b1; i_pc_ff = 32'h400;
    tick();
    i_valid = 1'b0;
`ifdef ZAP_FETCH_BP_EN
    check("bp_nowrite", 32'(o_taken_ff), 32'(WNT));
`else
    check("bp_absent", 32'(o_taken_ff), 32'(SNT));
`endif
    wb_flush();

`ifdef ZAP_FETCH_BP_EN
    // Confirm WT -> ST with a same-cycle push seeing the old state; clear ST -> WT.
    i_clear_from_alu = 1'b1; i_pc_from_alu = 32'h500; i_taken = 2'(WNT);
    tick();
    i_clear_from_alu = 1'b0;
    i_confirm_from_alu = 1'b1; i_taken = 2'(WT);
    i_valid = 1'b1; i_pc_ff = 32'h500;
    tick();
    i_confirm_from_alu = 1'b0; i_valid = 1'b0;
    #1;
    check("bp_old_value", 32'(o_taken_ff), 32'(WT));
    wb_flush();
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check("bp_confirm", 32'(o_taken_ff), 32'(ST));
    wb_flush();
    i_clear_from_alu = 1'b1; i_taken = 2'(ST); i_valid = 1'b1;
    tick();
    i_clear_from_alu = 1'b0;
    #1;
    check("bp_flush_drop", 32'(o_level), 32'd0);
    tick();
    i_valid = 1'b0;
    check("bp_clear", 32'(o_taken_ff), 32'(WT));
    wb_flush();
`endif

    // Reset in mid-operation discards entries.
    i_valid = 1'b1; i_pc_ff = 32'h600; i_instruction = 32'h55;
    tick();
    tick();
    i_valid = 1'b0;
    check("pre_rst_level", 32'(o_level), 32'd2);
    i_reset_n = 1'b0;
    tick();
    check("mid_rst_level", 32'(o_level), 32'd0);
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_pc8", o_pc_plus_8_ff, 32'd8);
    i_reset_n = 1'b1;
    i_stall_from_issue = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/zap_prefetch_queue.md
ZAP_PREFETCH_QUEUE -- requirements
Module: zap_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of 2, >=2).
REQ-002 SHALL have parameter BP_ENTRIES, default 1024, meaning branch-predictor counters (power of 2).
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- i_clk  in  1  single clock, all logic on rising edge.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode, i_clear_from_decode  in  1 each  pipeline control, listed highest to lowest priority.
- i_pc_ff  in  32  PC of the incoming word.
- i_cpsr_t  in  1  Thumb/compressed mode bit.
- i_instruction  in  32  I-cache word.
- i_valid  in  1  I-cache word valid.
- i_instr_abort  in  1  fetch abort for the word.
- o_ready  out  1  queue accepts a word this cycle.
- o_instruction  out  32  head instruction.
- o_valid  out  1  head entry valid.
- o_instr_abort  out  1  head abort flag.
- o_pc_ff  out  32  head PC.
- o_pc_plus_8_ff  out  32  head PC+8 (ARM) or PC+4 (T).
- o_taken_ff  out  2  head predictor state.
- o_level  out  $clog2(DEPTH)+1  occupancy.
- i_confirm_from_alu  in  1  prediction confirmed.
- i_pc_from_alu  in  32  PC of resolved branch.
- i_taken  in  2  predictor state carried with the resolved branch.

Function
REQ-004 SHALL define stall = i_data_stall|i_stall_from_shifter|i_stall_from_issue|i_stall_from_decode.
REQ-005 SHALL define flush = i_clear_from_writeback | (!i_data_stall & i_clear_from_alu) | (!stall & i_clear_from_decode).
REQ-006 SHALL drive o_ready = !full & !sleep & !flush.
REQ-007 SHALL push when i_valid & o_ready, storing {instruction, abort, pc, pc+(i_cpsr_t?4:8) mod 2^32, predictor counter at i_pc_ff[$clog2(BP_ENTRIES):1]}.
REQ-008 SHALL store instruction 32'd0 when i_instr_abort=1 and set sleep; sleep SHALL block pushes until flush.
REQ-009 SHALL pop the head when o_valid & !stall & !flush; push and pop in the same cycle SHALL leave o_level unchanged.
REQ-010 SHALL present a word pushed in cycle N at the outputs no earlier than cycle N+1 (no combinational bypass); head outputs SHALL hold while stall=1.
REQ-011 SHALL drive o_valid=0 when empty; head fields are don't-care while o_valid=0.
REQ-012 On flush SHALL empty the queue, clear sleep, and drop any same-cycle push, with o_valid=0 in the next cycle.
REQ-013 Read/write pointers SHALL wrap modulo DEPTH; o_level SHALL reach DEPTH exactly when full.
REQ-014 SHALL write the predictor counter at i_pc_from_alu[$clog2(BP_ENTRIES):1] when !i_data_stall & (i_clear_from_alu | i_confirm_from_alu).
REQ-015 On clear_from_alu the update SHALL be SNT->WNT, WNT->WT, WT->WNT, ST->WT; on confirm only SNT->SNT, WNT->SNT, WT->ST, ST->ST.
REQ-016 A push that reads the counter being written in the same cycle SHALL capture the old value.

Reset
REQ-017 While i_reset_n=0 at a clock edge SHALL set: level 0, pointers 0, sleep 0, o_valid 0, o_instr_abort 0, o_pc_ff 0, o_pc_plus_8_ff 8, o_taken_ff 0, o_ready 0.
REQ-018 Predictor counters SHALL NOT be reset.
REQ-019 Reset asserted mid-operation SHALL discard all entries.

Configuration
REQ-020 With ZAP_FETCH_BP_EN defined the predictor SHALL be present per REQ-014..016.
REQ-021 Without ZAP_FETCH_BP_EN no counter storage SHALL exist, o_taken_ff SHALL be 2'd0 (SNT), and the i_confirm_from_alu, i_pc_from_alu and i_taken inputs SHALL be unused.

Structure
REQ-022 The shared package zap_fetch_pkg SHALL hold SNT=0, WNT=1, WT=2, ST=3, ABORT_PAYLOAD=32'd0 and the queue-entry field layout.
REQ-023 The predictor SHALL be sub-module zap_bp_table (combinational read, synchronous write).

Verification
REQ-024 Bench SHALL cover: 4 pushes with DEPTH=4 and stall=1 -> o_level=4, o_ready=0, the 5th word is not accepted, and after release the words pop in order.
REQ-025 Bench SHALL cover: push at pc=0x100 with T=0, then pc=0x104 with T=1 -> o_pc_plus_8_ff of 0x108, then 0x108.
REQ-026 Bench SHALL cover: abort at pc=0x200 -> head entry {instruction=0, abort=1}, o_ready=0 until i_clear_from_alu, and o_valid=0 in the cycle after the clear.
REQ-027 Bench SHALL cover: i_clear_from_alu with i_data_stall=1 -> no flush and no predictor write; i_clear_from_writeback with i_data_stall=1 -> flush.
REQ-028 Bench SHALL cover: i_taken=WT with confirm -> counter becomes ST; i_taken=ST with clear_from_alu -> counter becomes WT; a push at the same index in the write cycle captures the old value.
